// File: rtl/fpdiv_res_queue.sv
// fpdiv_res_queue: result FIFO behind the FP divider.
// Buffers up to DEPTH finished results with their exception flags.
// On dequeue, f16 and f32 results are NaN-boxed to the full register width.
// It also keeps a sticky OR of the flags of every dequeued result for fcsr.fflags.
//
// Handshake semantics (both ports):
//   - A transfer fires on a rising clk edge where valid and ready are both 1.
//   - enq_ready_o depends only on registered occupancy, never on deq_ready_i.
//   - deq_valid_o depends only on registered occupancy, never on enq_valid_i.
//   - There is no flow-through. An entry accepted at edge N is first offered in cycle N+1.
module fpdiv_res_queue #(
    parameter int DEPTH    = 4,
    parameter int RES_W    = 64,
    parameter int FFLAGS_W = 5,
    parameter int PTR_W    = $clog2(DEPTH),
    parameter int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush_i,
    input  logic                enq_valid_i,
    output logic                enq_ready_o,
    input  logic [1:0]          enq_fp_format_i,
    input  logic [RES_W-1:0]    enq_res_i,
    input  logic [FFLAGS_W-1:0] enq_fflags_i,
    output logic                deq_valid_o,
    input  logic                deq_ready_i,
    output logic [RES_W-1:0]    deq_res_o,
    output logic [FFLAGS_W-1:0] deq_fflags_o,
    output logic [FFLAGS_W-1:0] fflags_acc_o,
    input  logic                fflags_clr_i,
    output logic [CNT_W-1:0]    count_o
);

    // Format codes as produced by the divider.
    localparam logic [1:0] FMT_F16 = 2'd0;
    localparam logic [1:0] FMT_F32 = 2'd1;

    typedef struct packed {
        logic [1:0]          fmt;
        logic [RES_W-1:0]    res;
        logic [FFLAGS_W-1:0] flags;
    } entry_t;

    // Storage. It is deliberately left without a reset; the valid window comes from count_q.
    entry_t mem_q [DEPTH];

    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q,  count_d;
    logic [FFLAGS_W-1:0] acc_q,    acc_d;

    logic   enq_fire;
    logic   deq_fire;
    entry_t head;
    entry_t enq_entry;

    // Handshake status comes from registered occupancy only.
    always_comb begin
        enq_ready_o = (count_q != CNT_W'(DEPTH));
        deq_valid_o = (count_q != '0);
        enq_fire    = enq_valid_i & enq_ready_o;
        deq_fire    = deq_valid_o & deq_ready_i;
        head        = mem_q[rd_ptr_q];
        enq_entry   = '{fmt: enq_fp_format_i, res: enq_res_i, flags: enq_fflags_i};
    end

    // Head presentation: NaN-box narrow formats, and force zero while the queue is empty.
    always_comb begin
        deq_res_o    = '0;
        deq_fflags_o = '0;
        if (deq_valid_o) begin
            deq_fflags_o = head.flags;
            case (head.fmt)
                FMT_F16: deq_res_o = {{(RES_W-16){1'b1}}, head.res[15:0]};
                FMT_F32: deq_res_o = {{(RES_W-32){1'b1}}, head.res[31:0]};
                default: deq_res_o = head.res;
            endcase
        end
    end

    // Next-state pointers, occupancy and sticky flags.
    // A flush discards any transfer in the same cycle but keeps the flag accumulation.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        acc_d    = fflags_clr_i ? '0 : acc_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq_fire) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (deq_fire) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                // A clear in the same cycle still lets the dequeued flags through.
                acc_d    = acc_d | head.flags;
            end
            case ({enq_fire, deq_fire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control registers, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            acc_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
        end
    end

    // Entry storage write. No write happens on a flushed enqueue.
    always_ff @(posedge clk) begin
        if (rst_n && enq_fire && !flush_i) begin
            mem_q[wr_ptr_q] <= enq_entry;
        end
    end

    assign fflags_acc_o = acc_q;
    assign count_o      = count_q;

endmodule

// File: tb/tb_fpdiv_res_queue.sv
// tb_fpdiv_res_queue: checks fpdiv_res_queue against a queue-based reference model.
// The run uses directed scenarios with literal expectations, then random traffic.
module tb_fpdiv_res_queue;

  localparam int DEPTH = 4;
  localparam int RES_W = 64;
  localparam int FW    = 5;
  localparam int CW    = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          flush_i;
  logic          enq_valid_i;
  logic          enq_ready_o;
  logic [1:0]    enq_fp_format_i;
  logic [RES_W-1:0] enq_res_i;
  logic [FW-1:0] enq_fflags_i;
  logic          deq_valid_o;
  logic          deq_ready_i;
  logic [RES_W-1:0] deq_res_o;
  logic [FW-1:0] deq_fflags_o;
  logic [FW-1:0] fflags_acc_o;
  logic          fflags_clr_i;
  logic [CW-1:0] count_o;

  fpdiv_res_queue #(.DEPTH(DEPTH), .RES_W(RES_W), .FFLAGS_W(FW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush_i         (flush_i),
    .enq_valid_i     (enq_valid_i),
    .enq_ready_o     (enq_ready_o),
    .enq_fp_format_i (enq_fp_format_i),
    .enq_res_i       (enq_res_i),
    .enq_fflags_i    (enq_fflags_i),
    .deq_valid_o     (deq_valid_o),
    .deq_ready_i     (deq_ready_i),
    .deq_res_o       (deq_res_o),
    .deq_fflags_o    (deq_fflags_o),
    .fflags_acc_o    (fflags_acc_o),
    .fflags_clr_i    (fflags_clr_i),
    .count_o         (count_o)
  );

  // ---------------- scoreboard / reference model ----------------
  typedef struct {
    logic [1:0]       fmt;
    logic [RES_W-1:0] res;
    logic [FW-1:0]    flags;
  } item_t;

  item_t         exp_q[$];
  logic [FW-1:0] model_acc;

  int checks = 0;
  int passed = 0;

  function automatic logic [RES_W-1:0] nan_box(input logic [1:0] fmt, input logic [RES_W-1:0] r);
    case (fmt)
      2'd0:    return {48'hFFFF_FFFF_FFFF, r[15:0]};
      2'd1:    return {32'hFFFF_FFFF, r[31:0]};
      default: return r;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Applies the behavioural rules for one clock edge, using the inputs as they are now driven.
  task automatic model_edge();
    bit enq_f, deq_f;
    item_t it;
    if (!rst_n) begin
      exp_q.delete();
      model_acc = '0;
      return;
    end
    enq_f = enq_valid_i && (exp_q.size() < DEPTH);
    deq_f = deq_ready_i && (exp_q.size() > 0);
    if (fflags_clr_i) model_acc = '0;
    if (flush_i) begin
      exp_q.delete();
      return;
    end
    if (deq_f) begin
      it = exp_q.pop_front();
      model_acc = model_acc | it.flags;
    end
    if (enq_f) begin
      it.fmt = enq_fp_format_i;
      it.res = enq_res_i;
      it.flags = enq_fflags_i;
      exp_q.push_back(it);
    end
  endtask

  // Compares every output with the model. It runs once per cycle, away from the active edge.
  task automatic compare_all();
    int n;
    n = exp_q.size();
    chk("count", 64'(count_o), 64'(n));
    chk("deq_valid", 64'(deq_valid_o), 64'(n != 0));
    chk("enq_ready", 64'(enq_ready_o), 64'(n != DEPTH));
    chk("deq_res", deq_res_o, (n != 0) ? nan_box(exp_q[0].fmt, exp_q[0].res) : 64'h0);
    chk("deq_fflags", 64'(deq_fflags_o), (n != 0) ? 64'(exp_q[0].flags) : 64'h0);
    chk("fflags_acc", 64'(fflags_acc_o), 64'(model_acc));
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    rst_n = 1'b1; flush_i = 1'b0; enq_valid_i = 1'b0; deq_ready_i = 1'b0;
    fflags_clr_i = 1'b0; enq_fp_format_i = 2'd0; enq_res_i = '0; enq_fflags_i = '0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_enq(input bit v, input logic [1:0] f, input logic [63:0] r, input logic [4:0] fl);
    enq_valid_i = v; enq_fp_format_i = f; enq_res_i = r; enq_fflags_i = fl;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_enq_ready", 64'(enq_ready_o), 64'd1);
    chk("rst_deq_res", deq_res_o, 64'd0);

    // 1: f64 result, visible the cycle after enqueue, then consumed
    idle_inputs();
    set_enq(1, 2'd2, 64'h3FF0_0000_0000_0000, 5'h01);
    deq_ready_i = 1'b1;
    tick();
    chk("s1_valid", 64'(deq_valid_o), 64'd1);
    chk("s1_res", deq_res_o, 64'h3FF0_0000_0000_0000);
    set_enq(0, 2'd0, 64'h0, 5'h0);
    tick();
    chk("s1_acc", 64'(fflags_acc_o), 64'h01);
    chk("s1_empty", 64'(count_o), 64'd0);

    // 2: NaN boxing of f16 and f32 results
    deq_ready_i = 1'b0;
    set_enq(1, 2'd0, 64'h0000_0000_0000_3C00, 5'h0);
    tick();
    set_enq(1, 2'd1, 64'h0000_0000_3F80_0000, 5'h0);
    tick();
    set_enq(0, 2'd0, 64'h0, 5'h0);
    chk("s2_f16", deq_res_o, 64'hFFFF_FFFF_FFFF_3C00);
    deq_ready_i = 1'b1;
    tick();
    chk("s2_f32", deq_res_o, 64'hFFFF_FFFF_3F80_0000);
    tick();

    // 3: fill to full, hold off a fifth, then accept it after one dequeue, across pointer wrap
    deq_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_enq(1, 2'd2, 64'hA0 + 64'(i), 5'(i));
      tick();
    end
    chk("s3_full_count", 64'(count_o), 64'd4);
    chk("s3_full_ready", 64'(enq_ready_o), 64'd0);
    set_enq(1, 2'd2, 64'hA4, 5'h4);
    tick();
    chk("s3_held", 64'(count_o), 64'd4);
    deq_ready_i = 1'b1;
    tick();
    chk("s3_after_deq", 64'(count_o), 64'd3);
    deq_ready_i = 1'b0;
    tick();
    chk("s3_fifth_in", 64'(count_o), 64'd4);
    set_enq(0, 2'd0, 64'h0, 5'h0);
    deq_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    // 4: simultaneous enqueue and dequeue at occupancy 2
    deq_ready_i = 1'b0;
    set_enq(1, 2'd2, 64'hB0, 5'h0); tick();
    set_enq(1, 2'd2, 64'hB1, 5'h0); tick();
    set_enq(1, 2'd2, 64'hB2, 5'h0);
    deq_ready_i = 1'b1;
    tick();
    chk("s4_count", 64'(count_o), 64'd2);
    chk("s4_head", deq_res_o, 64'hB1);
    set_enq(0, 2'd0, 64'h0, 5'h0);
    tick(); tick();

    // 5: clear coinciding with a dequeue keeps the dequeued flags
    deq_ready_i = 1'b0;
    fflags_clr_i = 1'b1; tick(); fflags_clr_i = 1'b0;
    set_enq(1, 2'd2, 64'hC0, 5'h03); tick();
    set_enq(1, 2'd2, 64'hC1, 5'h10); tick();
    set_enq(0, 2'd0, 64'h0, 5'h0);
    deq_ready_i = 1'b1; tick();
    chk("s5_acc_pre", 64'(fflags_acc_o), 64'h03);
    fflags_clr_i = 1'b1; tick(); fflags_clr_i = 1'b0;
    chk("s5_acc", 64'(fflags_acc_o), 64'h10);

    // 6: flush with an enqueue in flight, then reset with entries queued
    deq_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_enq(1, 2'd1, 64'hD0 + 64'(i), 5'h08); tick();
    end
    flush_i = 1'b1; tick(); flush_i = 1'b0;
    set_enq(0, 2'd0, 64'h0, 5'h0);
    chk("s6_count", 64'(count_o), 64'd0);
    chk("s6_valid", 64'(deq_valid_o), 64'd0);
    chk("s6_ready", 64'(enq_ready_o), 64'd1);
    chk("s6_acc_kept", 64'(fflags_acc_o), 64'h10);
    set_enq(1, 2'd2, 64'hE0, 5'h1); tick(); tick();
    set_enq(0, 2'd0, 64'h0, 5'h0);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("s6_rst_count", 64'(count_o), 64'd0);
    chk("s6_rst_acc", 64'(fflags_acc_o), 64'd0);
    chk("s6_rst_fflags", 64'(deq_fflags_o), 64'd0);

    // random traffic with stalls, occasional flush/clear/reset
    for (int c = 0; c < 3000; c++) begin
      enq_valid_i     = ($urandom_range(0, 99) < 60);
      enq_fp_format_i = 2'($urandom_range(0, 3));
      enq_res_i       = {$urandom, $urandom};
      enq_fflags_i    = 5'($urandom_range(0, 31));
      deq_ready_i     = ($urandom_range(0, 99) < 50);
      flush_i         = ($urandom_range(0, 99) < 3);
      fflags_clr_i    = ($urandom_range(0, 99) < 5);
      rst_n           = !($urandom_range(0, 999) < 5);
      tick();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
